// File: rtl/mips_ex_pkg.sv
// Shared EX-stage types and constants for the ALU arbiter.
// Starvation override is enabled by defining MIPS_EX_ALU_ARB_STARVE_EN.
package mips_ex_pkg;

    localparam int MIPS_DATA_WIDTH     = 32;
    localparam int MIPS_ALU_CTRL_WIDTH = 10;

    // One-hot ALU control bit positions
    localparam int MIPS_ALU_ADD     = 0;
    localparam int MIPS_ALU_SUB     = 1;
    localparam int MIPS_ALU_CMP_GEZ = 2;
    localparam int MIPS_ALU_CMP_LTZ = 3;
    localparam int MIPS_ALU_CMP_EQ  = 4;
    localparam int MIPS_ALU_CMP_NE  = 5;
    localparam int MIPS_ALU_CMP_LEZ = 6;
    localparam int MIPS_ALU_CMP_GTZ = 7;
    localparam int MIPS_ALU_LOGIC   = 8;
    localparam int MIPS_ALU_SHIFT   = 9;

    typedef enum logic {
        MIPS_ALU_ARB_S_SHARED   = 1'b0,
        MIPS_ALU_ARB_S_MDU_LOCK = 1'b1
    } mips_alu_arb_state_e;

    typedef enum logic {
        MIPS_ALU_OWN_PIPE = 1'b0,
        MIPS_ALU_OWN_MDU  = 1'b1
    } mips_alu_own_e;

endpackage

// File: rtl/mips_ex_alu_arb_starve.sv
// Saturating count of consecutive cycles the MDU was denied the ALU.
// Only instantiated when MIPS_EX_ALU_ARB_STARVE_EN is defined.
module mips_ex_alu_arb_starve (
    input  logic       clk,
    input  logic       rst,
    input  logic       mdu_vld_i,
    input  logic       mdu_rdy_i,
    output logic [3:0] cnt_o
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!mdu_vld_i || mdu_rdy_i) begin
            cnt_d = '0;
        end else if (cnt_q != 4'hF) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mips_ex_alu_arb.sv
// Arbiter/sequencer for the shared EX-stage ALU (pipeline vs. MDU).
// Define MIPS_EX_ALU_ARB_STARVE_EN to add the MDU starvation override.
module mips_ex_alu_arb
    import mips_ex_pkg::*;
#(
    parameter int DW         = MIPS_DATA_WIDTH,
    parameter int CW         = MIPS_ALU_CTRL_WIDTH,
    parameter int STARVE_MAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pipe_req_vld,
    output logic          pipe_req_rdy,
    input  logic [DW-1:0] pipe_req_op1,
    input  logic [DW-1:0] pipe_req_op2,
    input  logic [CW-1:0] pipe_req_ctrl,
    input  logic          mdu_req_vld,
    input  logic          mdu_req_lock,
    output logic          mdu_req_rdy,
    input  logic [DW-1:0] mdu_req_op1,
    input  logic [DW-1:0] mdu_req_op2,
    input  logic [CW-1:0] mdu_req_ctrl,
    input  logic          ex_flush,
    output logic [DW-1:0] alu_op1,
    output logic [DW-1:0] alu_op2,
    output logic [CW-1:0] alu_ctrl,
    input  logic [DW-1:0] alu_res,
    input  logic          alu_cmp,
    output logic          pipe_rsp_vld,
    output logic [DW-1:0] pipe_rsp_res,
    output logic          pipe_rsp_cmp,
    output logic          mdu_rsp_vld,
    output logic [DW-1:0] mdu_rsp_res
);

    mips_alu_arb_state_e state_q;
    mips_alu_arb_state_e state_d;

    logic          pipe_gnt;
    logic          mdu_gnt;
    logic          starve;

    logic          rsp_vld_q;
    logic          rsp_vld_d;
    mips_alu_own_e rsp_own_q;
    mips_alu_own_e rsp_own_d;
    logic [DW-1:0] rsp_res_q;
    logic [DW-1:0] rsp_res_d;
    logic          rsp_cmp_q;
    logic          rsp_cmp_d;

`ifdef MIPS_EX_ALU_ARB_STARVE_EN
    logic [3:0] starve_cnt;

    mips_ex_alu_arb_starve u_starve (
        .clk       (clk),
        .rst       (rst),
        .mdu_vld_i (mdu_req_vld),
        .mdu_rdy_i (mdu_req_rdy),
        .cnt_o     (starve_cnt)
    );

    assign starve = (starve_cnt == 4'(STARVE_MAX));
`else
    // Strict pipeline priority; the starvation limit has no effect here.
    assign starve = 1'b0 & (STARVE_MAX != 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MIPS_ALU_ARB_S_SHARED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MIPS_ALU_ARB_S_SHARED: begin
                if (mdu_gnt && mdu_req_lock) begin
                    state_d = MIPS_ALU_ARB_S_MDU_LOCK;
                end
            end
            MIPS_ALU_ARB_S_MDU_LOCK: begin
                if (mdu_gnt && !mdu_req_lock) begin
                    state_d = MIPS_ALU_ARB_S_SHARED;
                end
            end
            default: state_d = MIPS_ALU_ARB_S_SHARED;
        endcase
    end

    // A flushed pipeline request yields the ALU to the MDU.
    always_comb begin
        pipe_gnt = 1'b0;
        mdu_gnt  = 1'b0;
        if (!rst) begin
            unique case (state_q)
                MIPS_ALU_ARB_S_SHARED: begin
                    if (starve && mdu_req_vld) begin
                        mdu_gnt = 1'b1;
                    end else if (pipe_req_vld && !ex_flush) begin
                        pipe_gnt = 1'b1;
                    end else begin
                        mdu_gnt = mdu_req_vld;
                    end
                end
                MIPS_ALU_ARB_S_MDU_LOCK: mdu_gnt = mdu_req_vld;
                default: ;
            endcase
        end
    end

    assign pipe_req_rdy = pipe_gnt;
    assign mdu_req_rdy  = mdu_gnt;

    assign alu_op1  = pipe_gnt ? pipe_req_op1 : mdu_req_op1;
    assign alu_op2  = pipe_gnt ? pipe_req_op2 : mdu_req_op2;
    assign alu_ctrl = pipe_gnt ? pipe_req_ctrl :
                      mdu_gnt  ? mdu_req_ctrl  : '0;

    always_comb begin
        rsp_vld_d = pipe_gnt | mdu_gnt;
        rsp_own_d = mdu_gnt ? MIPS_ALU_OWN_MDU : MIPS_ALU_OWN_PIPE;
        rsp_res_d = rsp_res_q;
        rsp_cmp_d = rsp_cmp_q;
        if (rsp_vld_d) begin
            rsp_res_d = alu_res;
            rsp_cmp_d = alu_cmp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_vld_q <= 1'b0;
            rsp_own_q <= MIPS_ALU_OWN_PIPE;
            rsp_res_q <= '0;
            rsp_cmp_q <= 1'b0;
        end else begin
            rsp_vld_q <= rsp_vld_d;
            rsp_own_q <= rsp_own_d;
            rsp_res_q <= rsp_res_d;
            rsp_cmp_q <= rsp_cmp_d;
        end
    end

    assign pipe_rsp_vld = rsp_vld_q && (rsp_own_q == MIPS_ALU_OWN_PIPE);
    assign mdu_rsp_vld  = rsp_vld_q && (rsp_own_q == MIPS_ALU_OWN_MDU);
    assign pipe_rsp_res = rsp_res_q;
    assign pipe_rsp_cmp = rsp_cmp_q;
    assign mdu_rsp_res  = rsp_res_q;

endmodule

// File: tb/tb_mips_ex_alu_arb.sv
// Self-checking bench for mips_ex_alu_arb: vector table, directed
// corner sequences and randomized traffic against a reference model.
module tb_mips_ex_alu_arb;
    import mips_ex_pkg::*;

    localparam int DW   = MIPS_DATA_WIDTH;
    localparam int CW   = MIPS_ALU_CTRL_WIDTH;
    localparam int SMAX = 8;
`ifdef MIPS_EX_ALU_ARB_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    localparam logic [CW-1:0] C_ADD = CW'(1);
    localparam logic [CW-1:0] C_SUB = CW'(2);
    localparam logic [CW-1:0] C_EQ  = CW'(16);
    localparam logic [CW-1:0] C_XOR = CW'(256);
    localparam logic [CW-1:0] C_SHL = CW'(512);

    logic          clk;
    logic          rst;
    logic          pipe_req_vld;
    logic          pipe_req_rdy;
    logic [DW-1:0] pipe_req_op1;
    logic [DW-1:0] pipe_req_op2;
    logic [CW-1:0] pipe_req_ctrl;
    logic          mdu_req_vld;
    logic          mdu_req_lock;
    logic          mdu_req_rdy;
    logic [DW-1:0] mdu_req_op1;
    logic [DW-1:0] mdu_req_op2;
    logic [CW-1:0] mdu_req_ctrl;
    logic          ex_flush;
    logic [DW-1:0] alu_op1;
    logic [DW-1:0] alu_op2;
    logic [CW-1:0] alu_ctrl;
    logic [DW-1:0] alu_res;
    logic          alu_cmp;
    logic          pipe_rsp_vld;
    logic [DW-1:0] pipe_rsp_res;
    logic          pipe_rsp_cmp;
    logic          mdu_rsp_vld;
    logic [DW-1:0] mdu_rsp_res;

    mips_ex_alu_arb #(
        .DW         (DW),
        .CW         (CW),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pipe_req_vld  (pipe_req_vld),
        .pipe_req_rdy  (pipe_req_rdy),
        .pipe_req_op1  (pipe_req_op1),
        .pipe_req_op2  (pipe_req_op2),
        .pipe_req_ctrl (pipe_req_ctrl),
        .mdu_req_vld   (mdu_req_vld),
        .mdu_req_lock  (mdu_req_lock),
        .mdu_req_rdy   (mdu_req_rdy),
        .mdu_req_op1   (mdu_req_op1),
        .mdu_req_op2   (mdu_req_op2),
        .mdu_req_ctrl  (mdu_req_ctrl),
        .ex_flush      (ex_flush),
        .alu_op1       (alu_op1),
        .alu_op2       (alu_op2),
        .alu_ctrl      (alu_ctrl),
        .alu_res       (alu_res),
        .alu_cmp       (alu_cmp),
        .pipe_rsp_vld  (pipe_rsp_vld),
        .pipe_rsp_res  (pipe_rsp_res),
        .pipe_rsp_cmp  (pipe_rsp_cmp),
        .mdu_rsp_vld   (mdu_rsp_vld),
        .mdu_rsp_res   (mdu_rsp_res)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural shared ALU: {cmp, result}
    function automatic logic [DW:0] alu_f(input logic [DW-1:0] a,
                                          input logic [DW-1:0] b,
                                          input logic [CW-1:0] c);
        logic [DW-1:0] r;
        logic          k;
        r = '0;
        k = 1'b0;
        if (c[0]) r = a + b;
        if (c[1]) r = a - b;
        if (c[2]) k = !a[DW-1];
        if (c[3]) k = a[DW-1];
        if (c[4]) k = (a == b);
        if (c[5]) k = (a != b);
        if (c[6]) k = a[DW-1] || (a == '0);
        if (c[7]) k = !a[DW-1] && (a != '0);
        if (c[8]) r = a ^ b;
        if (c[9]) r = a << b[4:0];
        return {k, r};
    endfunction

    always_comb {alu_cmp, alu_res} = alu_f(alu_op1, alu_op2, alu_ctrl);

    typedef struct {
        logic          rst;
        logic          pv;
        logic [DW-1:0] pa;
        logic [DW-1:0] pb;
        logic [CW-1:0] pc;
        logic          mv;
        logic          ml;
        logic [DW-1:0] ma;
        logic [DW-1:0] mb;
        logic [CW-1:0] mc;
        logic          fl;
    } stim_t;

    typedef struct {
        logic          prdy;
        logic          mrdy;
        logic          pvld;
        logic          mvld;
        logic [DW-1:0] res;
        logic          cmp;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    int n_chk;
    int n_pass;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic stim_t st(input logic pv, input logic [DW-1:0] pa,
                                 input logic [DW-1:0] pb,
                                 input logic [CW-1:0] pc,
                                 input logic mv, input logic ml,
                                 input logic [DW-1:0] ma,
                                 input logic [DW-1:0] mb,
                                 input logic [CW-1:0] mc,
                                 input logic fl);
        stim_t s;
        s.rst = 1'b0;
        s.pv = pv; s.pa = pa; s.pb = pb; s.pc = pc;
        s.mv = mv; s.ml = ml; s.ma = ma; s.mb = mb; s.mc = mc;
        s.fl = fl;
        return s;
    endfunction

    // A grant in one cycle implies a response of the same owner next cycle.
    function automatic exp_t ex(input logic prdy, input logic mrdy,
                                input logic [DW-1:0] res, input logic cmp);
        exp_t e;
        e.prdy = prdy; e.mrdy = mrdy;
        e.pvld = prdy; e.mvld = mrdy;
        e.res = res; e.cmp = cmp;
        return e;
    endfunction

    // Entered at posedge+1: drive, check grants at negedge, check responses.
    task automatic run_cyc(input string tag, input stim_t s, input exp_t e);
        logic [CW-1:0] ectl;
        rst           = s.rst;
        pipe_req_vld  = s.pv;
        pipe_req_op1  = s.pa;
        pipe_req_op2  = s.pb;
        pipe_req_ctrl = s.pc;
        mdu_req_vld   = s.mv;
        mdu_req_lock  = s.ml;
        mdu_req_op1   = s.ma;
        mdu_req_op2   = s.mb;
        mdu_req_ctrl  = s.mc;
        ex_flush      = s.fl;
        #4;
        ectl = e.prdy ? s.pc : (e.mrdy ? s.mc : '0);
        chk({tag, ".pipe_rdy"}, 64'(pipe_req_rdy), 64'(e.prdy));
        chk({tag, ".mdu_rdy"}, 64'(mdu_req_rdy), 64'(e.mrdy));
        chk({tag, ".alu_ctrl"}, 64'(alu_ctrl), 64'(ectl));
        @(posedge clk);
        #1;
        chk({tag, ".pipe_rsp_vld"}, 64'(pipe_rsp_vld), 64'(e.pvld));
        chk({tag, ".mdu_rsp_vld"}, 64'(mdu_rsp_vld), 64'(e.mvld));
        if (e.pvld) begin
            chk({tag, ".pipe_rsp_res"}, 64'(pipe_rsp_res), 64'(e.res));
            chk({tag, ".pipe_rsp_cmp"}, 64'(pipe_rsp_cmp), 64'(e.cmp));
        end
        if (e.mvld) begin
            chk({tag, ".mdu_rsp_res"}, 64'(mdu_rsp_res), 64'(e.res));
        end
    endtask

    // Reference model state: lock ownership and consecutive MDU denials.
    bit m_lock;
    int m_cnt;

    task automatic model(input stim_t s, output exp_t e);
        logic [DW:0] r;
        e.prdy = 1'b0; e.mrdy = 1'b0; e.pvld = 1'b0; e.mvld = 1'b0;
        e.res = '0; e.cmp = 1'b0;
        if (s.rst) begin
            m_lock = 1'b0;
            m_cnt  = 0;
            return;
        end
        if (m_lock) e.mrdy = s.mv;
        else if (STARVE_ON && m_cnt == SMAX && s.mv) e.mrdy = 1'b1;
        else if (s.pv && !s.fl) e.prdy = 1'b1;
        else e.mrdy = s.mv;
        if (e.mrdy) m_lock = s.ml;
        if (!s.mv || e.mrdy) m_cnt = 0;
        else if (m_cnt < 15) m_cnt = m_cnt + 1;
        r = e.prdy ? alu_f(s.pa, s.pb, s.pc) : alu_f(s.ma, s.mb, s.mc);
        e.pvld = e.prdy;
        e.mvld = e.mrdy;
        e.res  = r[DW-1:0];
        e.cmp  = r[DW];
    endtask

    vec_t tbl[$];

    initial begin
        stim_t s;
        exp_t  e;
        exp_t  z;
        n_chk = 0;
        n_pass = 0;
        m_lock = 1'b0;
        m_cnt = 0;
        rst = 1'b1;
        pipe_req_vld = 1'b0; pipe_req_op1 = '0; pipe_req_op2 = '0;
        pipe_req_ctrl = '0; mdu_req_vld = 1'b0; mdu_req_lock = 1'b0;
        mdu_req_op1 = '0; mdu_req_op2 = '0; mdu_req_ctrl = '0;
        ex_flush = 1'b0;
        z = ex(1'b0, 1'b0, '0, 1'b0);

        tbl.push_back('{st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0)});
        tbl.push_back('{st(1, 5, 7, C_ADD, 0, 0, 0, 0, 0, 0), ex(1, 0, 12, 0)});
        tbl.push_back('{st(1, 1, 2, C_ADD, 1, 0, 3, 4, C_ADD, 0), ex(1, 0, 3, 0)});
        tbl.push_back('{st(0, 0, 0, 0, 1, 0, 3, 4, C_ADD, 0), ex(0, 1, 7, 0)});
        tbl.push_back('{st(1, 20, 5, C_SUB, 0, 0, 0, 0, 0, 0), ex(1, 0, 15, 0)});
        tbl.push_back('{st(1, 'hF0, 'hFF, C_XOR, 0, 0, 0, 0, 0, 0), ex(1, 0, 'h0F, 0)});
        tbl.push_back('{st(1, 1, 4, C_SHL, 0, 0, 0, 0, 0, 0), ex(1, 0, 16, 0)});
        tbl.push_back('{st(1, 9, 9, C_EQ, 0, 0, 0, 0, 0, 1), ex(0, 0, 0, 0)});
        tbl.push_back('{st(1, 9, 9, C_EQ, 0, 0, 0, 0, 0, 0), ex(1, 0, 0, 1)});
        tbl.push_back('{st(1, 9, 9, C_EQ, 1, 1, 1, 1, C_ADD, 1), ex(0, 1, 2, 0)});
        tbl.push_back('{st(1, 10, 1, C_ADD, 1, 1, 2, 2, C_ADD, 0), ex(0, 1, 4, 0)});
        tbl.push_back('{st(1, 10, 1, C_ADD, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0)});
        tbl.push_back('{st(1, 10, 1, C_ADD, 1, 1, 3, 3, C_ADD, 1), ex(0, 1, 6, 0)});
        tbl.push_back('{st(1, 10, 1, C_ADD, 1, 0, 4, 4, C_ADD, 0), ex(0, 1, 8, 0)});
        tbl.push_back('{st(1, 10, 1, C_ADD, 0, 0, 0, 0, 0, 0), ex(1, 0, 11, 0)});

        @(posedge clk);
        #1;

        // Reset held with both requesters asking: nothing may be granted.
        for (int i = 0; i < 2; i++) begin
            s = st(1, 3, 3, C_ADD, 1, 1, 4, 4, C_SUB, 0);
            s.rst = 1'b1;
            run_cyc($sformatf("reset%0d", i), s, z);
        end
        chk("reset.pipe_rsp_res", 64'(pipe_rsp_res), 64'd0);
        chk("reset.mdu_rsp_res", 64'(mdu_rsp_res), 64'd0);
        chk("reset.pipe_rsp_cmp", 64'(pipe_rsp_cmp), 64'd0);

        foreach (tbl[i]) begin
            run_cyc($sformatf("vec%0d", i), tbl[i].s, tbl[i].e);
        end

        // Both requesters held valid: starvation override or strict priority.
        run_cyc("starve.idle0", st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), z);
        for (int i = 0; i < 10; i++) begin
            if (STARVE_ON && i == SMAX) e = ex(0, 1, 4, 0);
            else e = ex(1, 0, 2, 0);
            run_cyc($sformatf("starve%0d", i),
                    st(1, 1, 1, C_ADD, 1, 0, 2, 2, C_ADD, 0), e);
        end
        run_cyc("starve.idle1", st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), z);

        // Reset in the middle of an MDU lock.
        run_cyc("rl.enter", st(0, 0, 0, 0, 1, 1, 5, 5, C_ADD, 0), ex(0, 1, 10, 0));
        s = st(1, 7, 7, C_ADD, 1, 1, 6, 6, C_ADD, 0);
        s.rst = 1'b1;
        run_cyc("rl.rst", s, z);
        run_cyc("rl.after", st(1, 7, 7, C_ADD, 1, 1, 6, 6, C_ADD, 0), ex(1, 0, 14, 0));
        run_cyc("rl.idle", st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), z);

        // Randomized traffic against the reference model.
        s = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        s.rst = 1'b1;
        model(s, e);
        run_cyc("rnd.rst", s, e);
        for (int i = 0; i < 400; i++) begin
            s.rst = ($urandom_range(0, 49) == 0);
            s.pv  = ($urandom_range(0, 9) < 7);
            s.pa  = $urandom;
            s.pb  = ($urandom_range(0, 3) == 0) ? s.pa : DW'($urandom);
            s.pc  = CW'(1) << $urandom_range(0, CW - 1);
            s.mv  = ($urandom_range(0, 9) < 6);
            s.ml  = ($urandom_range(0, 9) < 5);
            s.ma  = $urandom;
            s.mb  = $urandom;
            s.mc  = CW'(1) << $urandom_range(0, CW - 1);
            s.fl  = ($urandom_range(0, 9) == 0);
            model(s, e);
            run_cyc($sformatf("rnd%0d", i), s, e);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
